// File: rtl/mux_arb_rr.sv
// ---------------------------------------------------------------------------
// mux_arb_rr
//   Parametrised N-channel, W-bit registered selector with a valid/ready
//   handshake on every input channel and a one-entry output register
//   (1-cycle latency, 1 word/cycle when out_ready is held high).
//
//   Selection modes:
//     mode = 0 : explicit, the channel is named by `select`
//     mode = 1 : round-robin, first valid channel at or after the pointer
//
//   Optional build macro: MUX_ARB_LOCK_EN
//     Adds in_last[CHANNELS-1:0]. In round-robin mode a transfer with
//     in_last=0 locks the grant onto that channel until a transfer with
//     in_last=1; the pointer only advances on that final transfer.
//
//   Ports:
//     clock      rising-edge clock
//     reset      synchronous, active-high reset
//     in_data    flat input bus, channel i at [i*WIDTH +: WIDTH]
//     in_valid   per-channel valid
//     in_ready   per-channel ready, at most one bit high (combinational)
//     mode       0 = explicit select, 1 = round-robin
//     select     channel index used in mode 0
//     out_data   registered data
//     out_chan   registered index of the channel that supplied out_data
//     out_valid  output register holds data
//     out_ready  consumer accepts out_data this cycle
//     in_last    (MUX_ARB_LOCK_EN only) last word of a locked burst
// ---------------------------------------------------------------------------
module mux_arb_rr #(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 32,
    parameter int SEL_BITS = 5
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [CHANNELS*WIDTH-1:0]    in_data,
    input  logic [CHANNELS-1:0]          in_valid,
    output logic [CHANNELS-1:0]          in_ready,
    input  logic                         mode,
    input  logic [SEL_BITS-1:0]          select,
    output logic [WIDTH-1:0]             out_data,
    output logic [SEL_BITS-1:0]          out_chan,
    output logic                         out_valid,
    input  logic                         out_ready
`ifdef MUX_ARB_LOCK_EN
    ,
    input  logic [CHANNELS-1:0]          in_last
`endif
);

    logic [WIDTH-1:0]    out_data_q;
    logic [SEL_BITS-1:0] out_chan_q;
    logic                out_valid_q;
    logic [SEL_BITS-1:0] ptr_q;
    logic [SEL_BITS-1:0] ptr_d;

    logic                load;
    logic [CHANNELS-1:0] sel_match;
    logic                sel_hit;
    logic                rr_hit;
    logic [SEL_BITS-1:0] rr_grant;
    logic                grant_valid;
    logic [SEL_BITS-1:0] grant;
    logic [WIDTH-1:0]    grant_data;
    logic                xfer;

`ifdef MUX_ARB_LOCK_EN
    logic                lock_q;
    logic [SEL_BITS-1:0] lock_ch_q;
    logic                last_hit;
`endif

    // One-entry output register: a new word may enter in the same cycle the
    // held word drains.
    assign load = !out_valid_q || out_ready;

    // Explicit mode: an out-of-range select matches no channel, so it can
    // never grant.
    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_sel
            assign sel_match[gi] = (select == SEL_BITS'(gi)) && in_valid[gi];
        end
    endgenerate
    assign sel_hit = |sel_match;

    // Round-robin scan: walk offsets from high to low so the valid channel
    // closest to ptr_q (in wrap-around order) is the last one written.
    always_comb begin
        rr_hit   = 1'b0;
        rr_grant = '0;
        for (int k = CHANNELS - 1; k >= 0; k--) begin
            int idx;
            idx = int'(ptr_q) + k;
            if (idx >= CHANNELS) begin
                idx = idx - CHANNELS;
            end
            if (in_valid[idx]) begin
                rr_hit   = 1'b1;
                rr_grant = SEL_BITS'(idx);
            end
        end
    end

    always_comb begin
        grant_valid = 1'b0;
        grant       = '0;
        if (!mode) begin
            grant_valid = sel_hit;
            grant       = select;
        end else begin
            grant_valid = rr_hit;
            grant       = rr_grant;
`ifdef MUX_ARB_LOCK_EN
            // A locked burst keeps its grant even while its valid is low.
            if (lock_q) begin
                grant_valid = 1'b1;
                grant       = lock_ch_q;
            end
`endif
        end
    end

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ready
            assign in_ready[gi] = !reset && load && grant_valid &&
                                  (grant == SEL_BITS'(gi));
        end
    endgenerate

    // in_ready is one-hot on the grant, so this covers only the granted lane.
    assign xfer = |(in_ready & in_valid);

`ifdef MUX_ARB_LOCK_EN
    assign last_hit = |(in_ready & in_last);
`endif

    always_comb begin
        grant_data = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (grant == SEL_BITS'(i)) begin
                grant_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign ptr_d = (grant == SEL_BITS'(CHANNELS - 1)) ? '0 : grant + SEL_BITS'(1);

    always_ff @(posedge clock) begin
        if (reset) begin
            out_data_q  <= '0;
            out_chan_q  <= '0;
            out_valid_q <= 1'b0;
            ptr_q       <= '0;
`ifdef MUX_ARB_LOCK_EN
            lock_q      <= 1'b0;
            lock_ch_q   <= '0;
`endif
        end else begin
            if (xfer) begin
                out_data_q  <= grant_data;
                out_chan_q  <= grant;
                out_valid_q <= 1'b1;
                if (mode) begin
`ifdef MUX_ARB_LOCK_EN
                    if (last_hit) begin
                        lock_q <= 1'b0;
                        ptr_q  <= ptr_d;
                    end else begin
                        lock_q    <= 1'b1;
                        lock_ch_q <= grant;
                    end
`else
                    ptr_q <= ptr_d;
`endif
                end
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
`ifdef MUX_ARB_LOCK_EN
            // Explicit mode abandons any burst in progress.
            if (!mode) begin
                lock_q <= 1'b0;
            end
`endif
        end
    end

    assign out_data  = out_data_q;
    assign out_chan  = out_chan_q;
    assign out_valid = out_valid_q;

endmodule
